axi_read_arbiter: RTL and testbench

Two-requester arbiter for the core's single AXI read master. It shares the AR and R channels of the top-level bus between instruction fetch (requester 0) and data load (requester 1). It issues one INCR burst at a time, routes returned beats to the owning requester and checks burst length against `rlast`. It sits between the fetch/load units and the `m_axi_ar*`/`m_axi_r*` ports.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/axi_read_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI read-side types and encodings. Provides the
//                arbiter state type and the fixed AR channel field values.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  // Normal non-cacheable bufferable, unprivileged secure data access.
  localparam logic [3:0] AXI_CACHE_NCB  = 4'b0011;
  localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant, purely combinational. When both
//                requesters are active the one that did not win last time
//                is granted; a lone requester always wins.
//  Ports       : req_i        - request vector
//                last_grant_i - index of the previous winner
//                gnt_o        - one-hot grant (zero when no request)
//                gnt_idx_o    - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_idx_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_grant_i;
    end else if (req_i[1]) begin
      gnt_idx_o = 1'b1;
    end
    gnt_o = 2'b00;
    if (|req_i) begin
      gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter
//  Description : Shares one AXI read master between instruction fetch (0) and
//                data load (1). One INCR burst outstanding at a time; R beats
//                are routed combinationally to the owner, and burst length /
//                ID are checked against rlast / rid.
//  Ports       : clk, reset (sync, active-low)
//                req_valid/req_ready, req_addr0/1, req_len0/1 - request side
//                resp_valid/resp_ready, resp_data/last/err     - beat side
//                proto_err                                     - sticky error
//                m_axi_ar*, m_axi_r*                           - AXI read bus
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [7:0]            req_len0,
  input  logic [7:0]            req_len1,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic                  proto_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  arb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [7:0]            beat_q, beat_d;
  logic                  proto_err_q, proto_err_d;

  logic [1:0]            w_gnt;
  logic                  w_gnt_idx;
  logic [ID_WIDTH-1:0]   w_owner_id;
  logic                  w_owner_ready;
  logic                  w_r_hs;
  logic                  w_unused_rresp0;

  rr_arbiter2 u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (w_gnt),
    .gnt_idx_o    (w_gnt_idx)
  );

  assign w_owner_id      = {{(ID_WIDTH-1){1'b0}}, owner_q};
  assign w_owner_ready   = owner_q ? resp_ready[1] : resp_ready[0];
  assign w_r_hs          = (state_q == DATA) && m_axi_rvalid && w_owner_ready;
  // Only the error bit of rresp is reported; EXOKAY is treated as success.
  assign w_unused_rresp0 = m_axi_rresp[0];

  // AR fields come straight from the latched request, so they are stable
  // for the whole ADDR phase regardless of arready timing.
  assign m_axi_arid    = w_owner_id;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_NCB;
  assign m_axi_arprot  = AXI_PROT_DATA;

  // Beat payload is shared; resp_valid alone says who it belongs to.
  assign resp_data = m_axi_rdata;
  assign resp_last = m_axi_rlast;
  assign resp_err  = m_axi_rresp[1];
  assign proto_err = proto_err_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    beat_d        = beat_q;
    proto_err_d   = proto_err_q;
    req_ready     = 2'b00;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    resp_valid    = 2'b00;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = w_gnt;
          owner_d   = w_gnt_idx;
          addr_d    = w_gnt_idx ? req_addr1 : req_addr0;
          len_d     = w_gnt_idx ? req_len1  : req_len0;
          state_d   = ADDR;
        end
      end

      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          beat_d  = 8'd0;
          state_d = DATA;
        end
      end

      DATA: begin
        resp_valid   = owner_q ? {m_axi_rvalid, 1'b0} : {1'b0, m_axi_rvalid};
        m_axi_rready = w_owner_ready;
        if (w_r_hs) begin
          // Saturate rather than wrap if a slave overruns a 256-beat burst.
          if (beat_q != 8'hFF) begin
            beat_d = beat_q + 8'd1;
          end
          if ((m_axi_rlast && (beat_q != len_q)) ||
              (!m_axi_rlast && (beat_q == len_q)) ||
              (m_axi_rid != w_owner_id)) begin
            proto_err_d = 1'b1;
          end
          if (m_axi_rlast) begin
            last_grant_d = owner_q;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= 8'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_q       <= 8'd0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_arbiter
//  Description : Self-checking bench for axi_read_arbiter. Acts as both
//                requesters and the AXI slave; expected grants, AR fields,
//                beat routing and sticky error are derived from the
//                arbitration rules kept in a small behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr0, req_addr1;
  logic [7:0]  req_len0, req_len1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [63:0] resp_data;
  logic        resp_last, resp_err, proto_err;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [12:0] m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: who won last, and whether an error was seen.
  int model_last_grant;
  bit model_perr;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .ID_WIDTH   (13),
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .req_len0      (req_len0),
    .req_len1      (req_len1),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_last     (resp_last),
    .resp_err      (resp_err),
    .proto_err     (proto_err),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arlock  (m_axi_arlock),
    .m_axi_arcache (m_axi_arcache),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request/burst. Error knobs (-1 = off):
  //   early_at   - beat index on which the slave asserts rlast prematurely
  //   bad_rid_at - beat index returned with the other requester's ID
  //   err_at     - beat index returned with SLVERR
  //   rst_at     - beat index during which reset is asserted
  task automatic do_burst(input logic [1:0] mask,
                          input logic [63:0] a0, input logic [63:0] a1,
                          input logic [7:0] l0, input logic [7:0] l1,
                          input int ar_wait, input int bp_pct,
                          input int early_at, input int bad_rid_at,
                          input int err_at, input int rst_at);
    int          w;
    logic [63:0] a;
    logic [7:0]  l;
    int          nbeats;
    int          accepted;
    int          tries;
    bit          done;
    bit          hs;
    bit          in_rst;
    logic [1:0]  onehot;
    logic [63:0] d;
    logic [1:0]  rr;
    logic        lst;
    bit          rid_bad;

    // Round-robin only breaks ties; a lone requester always wins.
    if (mask == 2'b11) w = (model_last_grant == 1) ? 0 : 1;
    else               w = mask[1] ? 1 : 0;
    a      = (w == 1) ? a1 : a0;
    l      = (w == 1) ? l1 : l0;
    onehot = (w == 1) ? 2'b10 : 2'b01;
    nbeats = (early_at >= 0) ? early_at + 1 : int'(l) + 1;

    // Request cycle
    req_valid = mask; req_addr0 = a0; req_addr1 = a1; req_len0 = l0; req_len1 = l1;
    @(negedge clk);
    check_eq("req_ready_grant", req_ready, onehot);
    check_eq("arvalid_idle", m_axi_arvalid, 0);
    tick();
    // Scramble request fields to prove the arbiter latched them.
    req_valid = mask; req_addr0 = {$urandom, $urandom}; req_addr1 = {$urandom, $urandom};
    req_len0 = 8'($urandom); req_len1 = 8'($urandom);

    for (int i = 0; i <= ar_wait; i++) begin
      m_axi_arready = (i == ar_wait);
      @(negedge clk);
      check_eq("arvalid", m_axi_arvalid, 1);
      check_eq("req_ready_busy", req_ready, 0);
      check_eq("araddr", m_axi_araddr, a);
      check_eq("arlen", m_axi_arlen, l);
      check_eq("arid", m_axi_arid, w);
      if (i == ar_wait) begin
        check_eq("arsize", m_axi_arsize, 3);
        check_eq("arburst", m_axi_arburst, 1);
        check_eq("arcache", m_axi_arcache, 3);
        check_eq("arprot", m_axi_arprot, 0);
        check_eq("arlock", m_axi_arlock, 0);
      end
      tick();
    end
    m_axi_arready = 1'b0;
    req_valid = 2'b00;

    accepted = 0;
    in_rst   = 0;
    for (int b = 0; b < nbeats && !in_rst; b++) begin
      tries = 0;
      done  = 0;
      d       = {$urandom, $urandom};
      rr      = (b == err_at) ? 2'b10 : {1'b0, 1'($urandom)};
      lst     = (b == nbeats - 1);
      rid_bad = (b == bad_rid_at);
      while (!done) begin
        if (tries < 8 && $urandom_range(0, 3) == 0 && b != rst_at) m_axi_rvalid = 1'b0;
        else m_axi_rvalid = 1'b1;
        m_axi_rdata = d; m_axi_rresp = rr; m_axi_rlast = lst;
        m_axi_rid   = rid_bad ? 13'(1 - w) : 13'(w);
        resp_ready = 2'($urandom);
        resp_ready[w] = (tries >= 8) ? 1'b1 : ($urandom_range(0, 99) >= bp_pct);
        if (b == rst_at && m_axi_rvalid) begin
          reset = 1'b0;
          in_rst = 1;
        end
        @(negedge clk);
        check_eq("resp_valid", resp_valid, m_axi_rvalid ? onehot : 2'b00);
        check_eq("rready", m_axi_rready, resp_ready[w]);
        check_eq("proto_err", proto_err, model_perr);
        if (m_axi_rvalid) begin
          check_eq("resp_data", resp_data, d);
          check_eq("resp_last", resp_last, lst);
          check_eq("resp_err", resp_err, rr[1]);
        end
        hs = m_axi_rvalid && m_axi_rready;
        if (resp_valid[w] && resp_ready[w]) accepted++;
        tick();
        if (in_rst) begin
          reset = 1'b1;
          model_last_grant = 1;
          model_perr = 0;
          resp_ready = 2'b11;
          @(negedge clk);
          check_eq("rst_arvalid", m_axi_arvalid, 0);
          check_eq("rst_rready", m_axi_rready, 0);
          check_eq("rst_resp_valid", resp_valid, 0);
          check_eq("rst_proto_err", proto_err, 0);
          tick();
          done = 1;
        end else if (hs) begin
          if ((lst && b != int'(l)) || (!lst && b == int'(l)) || rid_bad) model_perr = 1;
          done = 1;
        end else begin
          tries++;
          if (tries > 40) begin
            check_eq("r_handshake_timeout", hs, 1);
            m_axi_rvalid = 1'b0;
            return;
          end
        end
      end
    end
    m_axi_rvalid = 1'b0;
    resp_ready   = 2'b00;
    if (in_rst) return;

    check_eq("beats_accepted", accepted, nbeats);
    model_last_grant = w;

    // IDLE gap: a stray beat must be neither accepted nor forwarded.
    m_axi_rvalid = 1'b1; m_axi_rdata = {$urandom, $urandom}; resp_ready = 2'b11;
    @(negedge clk);
    check_eq("idle_rready", m_axi_rready, 0);
    check_eq("idle_resp_valid", resp_valid, 0);
    check_eq("idle_arvalid", m_axi_arvalid, 0);
    check_eq("idle_proto_err", proto_err, model_perr);
    tick();
    m_axi_rvalid = 1'b0; resp_ready = 2'b00;
  endtask

  initial begin
    reset = 1'b0; req_valid = 2'b00; req_addr0 = '0; req_addr1 = '0;
    req_len0 = '0; req_len1 = '0; resp_ready = 2'b00; m_axi_arready = 1'b0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b1;
    model_last_grant = 1;
    model_perr = 0;

    tick(); tick();
    resp_ready = 2'b11;
    @(negedge clk);
    check_eq("reset_arvalid", m_axi_arvalid, 0);
    check_eq("reset_rready", m_axi_rready, 0);
    check_eq("reset_resp_valid", resp_valid, 0);
    check_eq("reset_proto_err", proto_err, 0);
    check_eq("reset_req_ready", req_ready, 0);
    tick();
    reset = 1'b1; m_axi_rvalid = 1'b0; resp_ready = 2'b00;
    tick();

    // Contention right after reset: req0 first, then req1, then req0 again.
    do_burst(2'b11, 64'h4000, 64'h8000, 8'd3, 8'd5, 0, 0, -1, -1, -1, -1);
    do_burst(2'b11, 64'h4100, 64'h8100, 8'd2, 8'd1, 1, 0, -1, -1, -1, -1);
    do_burst(2'b11, 64'h4200, 64'h8200, 8'd0, 8'd0, 0, 0, -1, -1, -1, -1);

    // Single fetch, arready after 2 cycles.
    do_burst(2'b01, 64'h1000, 64'h0, 8'd7, 8'd0, 2, 0, -1, -1, -1, -1);
    // Repeated lone requester keeps winning.
    do_burst(2'b01, 64'h1040, 64'h0, 8'd1, 8'd0, 0, 0, -1, -1, -1, -1);
    // Back-pressure on req1.
    do_burst(2'b10, 64'h0, 64'h9000, 8'd0, 8'd3, 0, 60, -1, -1, -1, -1);
    // SLVERR on one beat.
    do_burst(2'b01, 64'h2000, 64'h0, 8'd4, 8'd0, 0, 20, -1, -1, 2, -1);
    // Maximum burst length.
    do_burst(2'b10, 64'h0, 64'hA000, 8'd0, 8'd255, 1, 10, -1, -1, -1, -1);

    for (int k = 0; k < 25; k++) begin
      do_burst(2'($urandom_range(1, 3)), {$urandom, $urandom}, {$urandom, $urandom},
               8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 60), -1, -1, -1, -1);
    end

    // Early rlast on beat 2 of 4; proto_err must stay up afterwards.
    do_burst(2'b10, 64'h0, 64'hB000, 8'd0, 8'd3, 0, 0, 1, -1, -1, -1);
    do_burst(2'b01, 64'hC000, 64'h0, 8'd2, 8'd0, 0, 0, -1, -1, -1, -1);

    // Reset during beat 3 of 8, then contention goes to req0.
    do_burst(2'b01, 64'hD000, 64'h0, 8'd7, 8'd0, 0, 0, -1, -1, -1, 2);
    do_burst(2'b11, 64'hD100, 64'hE100, 8'd1, 8'd1, 0, 0, -1, -1, -1, -1);

    // Wrong ID during a req0 burst.
    do_burst(2'b01, 64'hF000, 64'h0, 8'd3, 8'd0, 0, 0, -1, 1, -1, -1);
    do_burst(2'b10, 64'h0, 64'hF100, 8'd0, 8'd2, 0, 0, -1, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
